// File: rtl/aes_ctrl_pkg.sv
// Shared types and default timing for the iterative AES-128 round controller.
package aes_ctrl_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned SR_LAT_DEF    = 2;
    localparam int unsigned MC_LAT_DEF    = 1;
    localparam int unsigned CNT_W_DEF     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_SUB  = 3'd2,
        ST_MIX  = 3'd3,
        ST_HOLD = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/aes_lat_timer.sv
// Loadable down-counter; done_o is high once the loaded count has drained to zero.
module aes_lat_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o,
    output logic         zero_next_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == '0);
    // Lets the owner register outputs that depend on the count after this edge.
    assign zero_next_o = (cnt_d == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the shared SubBytes/ShiftRows and MixColumns/AddRoundKey stages.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
    parameter int unsigned SR_LAT     = SR_LAT_DEF,
    parameter int unsigned MC_LAT     = MC_LAT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iKeyReady,
    input  logic             iStart,
    output logic             oReady,
    output logic             oLdState,
    output logic             oSelFeedback,
    output logic [CNT_W-1:0] oKeyAddr,
    output logic             oSkipMix,
    output logic [CNT_W-1:0] oRound,
    output logic             oBusy,
    output logic             oValid,
    input  logic             iOutReady
);

    localparam logic [CNT_W-1:0] SR_LOAD  = CNT_W'(SR_LAT - 1);
    localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             tmr_zero_next;

    logic             ld_q, ld_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] key_q, key_d;
    logic             skip_q, skip_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    aes_lat_timer #(.W(CNT_W)) u_lat_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .done_o      (tmr_done),
        .zero_next_o (tmr_zero_next)
    );

    // Next state, round counter and timer reloads.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (iStart && iKeyReady) begin
                    state_d = ST_INIT;
                    round_d = '0;
                end
            end
            ST_INIT: begin
                state_d  = ST_SUB;
                round_d  = CNT_W'(1);
                tmr_load = 1'b1;
                tmr_val  = SR_LOAD;
            end
            ST_SUB: begin
                if (tmr_done) begin
                    state_d  = ST_MIX;
                    tmr_load = 1'b1;
                    tmr_val  = MC_LOAD;
                end
            end
            ST_MIX: begin
                if (tmr_done) begin
                    if (round_q < LAST_RND) begin
                        state_d  = ST_SUB;
                        round_d  = round_q + CNT_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = SR_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (iOutReady) begin
                    state_d = ST_IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they line up with it.
    always_comb begin
        ld_d    = (state_d == ST_INIT) || ((state_d == ST_MIX) && tmr_zero_next);
        sel_d   = (state_d == ST_MIX);
        key_d   = (state_d == ST_MIX) ? round_d : '0;
        skip_d  = (state_d == ST_MIX) && (round_d == LAST_RND);
        busy_d  = (state_d == ST_INIT) || (state_d == ST_SUB) || (state_d == ST_MIX);
        valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            ld_q    <= 1'b0;
            sel_q   <= 1'b0;
            key_q   <= '0;
            skip_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ld_q    <= ld_d;
            sel_q   <= sel_d;
            key_q   <= key_d;
            skip_q  <= skip_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign oReady       = (state_q == ST_IDLE) && iKeyReady;
    assign oLdState     = ld_q;
    assign oSelFeedback = sel_q;
    assign oKeyAddr     = key_q;
    assign oSkipMix     = skip_q;
    assign oRound       = round_q;
    assign oBusy        = busy_q;
    assign oValid       = valid_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencing controller for the iterative AES-128 encryption round datapath. It shares one SubBytes/ShiftRows stage (2-cycle latency: registered ROM plus output register) and one MixColumns/AddRoundKey stage across all 10 rounds. It accepts a start handshake, generates the state-register load and mux selects, the round-key address and the last-round MixColumns bypass, then holds the result valid until the consumer accepts it.

Parameters:
NUM_ROUNDS, 10, number of AES rounds after the initial AddRoundKey.
SR_LAT, 2, cycles from state register to registered SubBytes/ShiftRows output.
MC_LAT, 1, cycles for MixColumns+AddRoundKey into the state register.
CNT_W, 4, width of the round and latency counters; must hold NUM_ROUNDS and max(SR_LAT, MC_LAT).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
iKeyReady  in  1  round-key expansion complete; key RAM readable.
iStart  in  1  request to encrypt the plaintext presented on the datapath input.
oReady  out  1  controller can accept iStart.
oLdState  out  1  state register load enable.
oSelFeedback  out  1  0: state <= plaintext ^ key[0]; 1: state <= MixColumns/AddRoundKey result.
oKeyAddr  out  CNT_W  round-key index driven to key RAM.
oSkipMix  out  1  bypass MixColumns (final round).
oRound  out  CNT_W  current round number, 0 in IDLE/INIT.
oBusy  out  1  encryption in progress (INIT, SUB or MIX).
oValid  out  1  ciphertext in state register is valid.
iOutReady  in  1  consumer accepts the ciphertext.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, counters 0. All outputs 0 except oReady, which follows the IDLE rule.
- States: IDLE, INIT, SUB, MIX, HOLD. Encoding is in the package.
- IDLE: oReady = iKeyReady. If iStart && iKeyReady, go to INIT. Otherwise stay in IDLE; iStart with iKeyReady=0 is ignored, not queued.
- INIT (1 cycle): oLdState=1, oSelFeedback=0, oKeyAddr=0. Round counter <= 1. Go to SUB.
- SUB (SR_LAT cycles): latency counter counts 0..SR_LAT-1. oLdState=0. On the last count go to MIX.
- MIX (MC_LAT cycles): oKeyAddr=round and oSkipMix=(round==NUM_ROUNDS) for every MIX cycle. oSelFeedback=1. oLdState=1 on the last MIX cycle only.
  - If round<NUM_ROUNDS: round++, go to SUB.
  - Else: go to HOLD.
- HOLD: oValid=1, oBusy=0, oReady=0. If iOutReady, go to IDLE on the next edge; oValid drops the same edge.
- Latency: with iStart sampled at edge 0, oValid rises after edge 2+NUM_ROUNDS*(SR_LAT+MC_LAT). With defaults this is edge 32.
- Throughput: one block per 33 cycles minimum. Back-to-back operation: HOLD accepted, IDLE, start in the next cycle.
- iStart outside IDLE is ignored; in-flight encryption is never restarted.
- iKeyReady dropping mid-operation is ignored. The key owner must not rewrite keys while oBusy=1; this is an assertion in the bench.
- oValid && !iOutReady: hold indefinitely. The state register is not loaded (oLdState=0), so the ciphertext is stable.
- rst_n low mid-operation: next edge forces IDLE with outputs zeroed. No partial result is ever flagged valid.
- Round counter never exceeds NUM_ROUNDS. The latency counter wraps to 0 on every state change.
- All outputs are registered or decoded from registered state only. No combinational path from iStart or iOutReady to any output except oReady (from iKeyReady, IDLE only).

Decomposition:
- Package aes_ctrl_pkg: state enum (IDLE, INIT, SUB, MIX, HOLD), AES128_ROUNDS=10, default SR_LAT/MC_LAT, CNT_W.
- One natural sub-module, aes_lat_timer: loadable down-counter giving a 'done' pulse after N cycles, reused for the SUB and MIX waits.
- The round counter and FSM stay in aes_round_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with iKeyReady=0 -> all outputs 0. Set iKeyReady=1 -> oReady=1 next cycle.
- Single encrypt (defaults): pulse iStart at edge 0, iOutReady=1 -> oLdState pulses at cycles 1,4,7,...,31 (11 pulses). oKeyAddr reads 0,1..10 at those pulses. oSkipMix=1 only at cycle 31. oValid=1 at cycle 32 for 1 cycle. End-to-end with the datapath: FIPS-197 vector pt 00112233445566778899aabbccddeeff, key 000102..0f -> ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
- Backpressure: iOutReady=0 for 20 cycles after oValid -> oValid stays 1, oLdState stays 0, ciphertext unchanged. Then iOutReady=1 -> IDLE next cycle.
- Ignored starts: iStart held high throughout an encryption -> exactly one encryption. A second starts only after the HOLD->IDLE transition. iStart with iKeyReady=0 -> no state change.
- Mid-run reset: assert rst_n=0 at cycle 15 of an encryption -> IDLE, oBusy=0, oValid never asserted. A new iStart 2 cycles later completes normally in 32 cycles.
- Parameter sweep SR_LAT=3, MC_LAT=2 -> oValid at edge 2+10*5=52, with 11 oLdState pulses spaced 5 cycles apart.
